medidor_faixa_mc: RTL and testbench

MEDIDOR_FAIXA_MC -- requirements
Module: medidor_faixa_mc

---
 rtl/medidor_faixa_mc.sv | 211 +++++++++++++++++++++
 tb/tb_medidor_faixa_mc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_faixa_mc.sv
// medidor_faixa_mc: multi-channel ultrasonic range meter with window check.
// Triggers each sensor in turn, times its echo and reports one result per channel.
module medidor_faixa_mc #(
    parameter int N_CH           = 2,
    parameter int W              = 12,
    parameter int CLK_PER_UNIT   = 2941,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_medir,
    input  logic            i_continuo,
    input  logic [W-1:0]    i_upperL,
    input  logic [W-1:0]    i_lowerL,
    input  logic [N_CH-1:0] i_echo,
    output logic [N_CH-1:0] o_trigger,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [2:0]      o_res_canal,
    output logic [W-1:0]    o_res_medida,
    output logic            o_res_dentro,
    output logic            o_res_timeout,
    output logic [N_CH-1:0] o_dentro,
    output logic            o_acertou,
    output logic [3:0]      o_db_estado
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_TRIG = 4'd1,
        S_WAIT = 4'd2,
        S_MEAS = 4'd3,
        S_RES  = 4'd4,
        S_NEXT = 4'd5,
        S_FIM  = 4'd6
    } state_t;

    localparam logic [31:0]  TRIG_LAST = TRIG_CYCLES - 1;
    localparam logic [31:0]  TMO_LAST  = TIMEOUT_CYCLES - 1;
    localparam logic [31:0]  UNIT_LAST = CLK_PER_UNIT - 1;
    localparam logic [W-1:0] MED_MAX   = '1;
    localparam logic [W-1:0] MED_PRE   = MED_MAX - 1'b1;
    // The cycle that shows the rising edge is already the first high cycle.
    localparam logic [W-1:0] MED_START = (CLK_PER_UNIT == 1) ? W'(1) : '0;
    localparam logic [31:0]  CNT_START = (CLK_PER_UNIT == 1) ? 32'd0 : 32'd1;

    state_t          r_state;
    logic [2:0]      r_ch;
    logic [31:0]     r_cnt;
    logic [W-1:0]    r_med;
    logic [W-1:0]    r_upper;
    logic [W-1:0]    r_lower;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic            r_echo_prev;
    logic [N_CH-1:0] r_trigger;
    logic            r_valid;
    logic            r_res_dentro;
    logic            r_res_to;
    logic [N_CH-1:0] r_dentro;
    logic            r_acertou;

    logic            w_echo;
    logic            w_hit;
    logic [N_CH-1:0] w_oh_ch;

    function automatic logic [N_CH-1:0] f_onehot(input logic [2:0] c);
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (c == 3'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        w_echo = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch == 3'(i)) w_echo = r_sync2[i];
        end
    end

    assign w_oh_ch = f_onehot(r_ch);
    assign w_hit   = (r_lower <= r_med) && (r_med <= r_upper);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_cnt        <= '0;
            r_med        <= '0;
            r_upper      <= '0;
            r_lower      <= '0;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_echo_prev  <= 1'b0;
            r_trigger    <= '0;
            r_valid      <= 1'b0;
            r_res_dentro <= 1'b0;
            r_res_to     <= 1'b0;
            r_dentro     <= '0;
            r_acertou    <= 1'b0;
        end else begin
            r_sync1     <= i_echo;
            r_sync2     <= r_sync1;
            r_echo_prev <= w_echo;
            r_acertou   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_medir || i_continuo) begin
                        r_state   <= S_TRIG;
                        r_ch      <= '0;
                        r_cnt     <= '0;
                        r_upper   <= i_upperL;
                        r_lower   <= i_lowerL;
                        r_trigger <= f_onehot(3'd0);
                    end
                end
                S_TRIG: begin
                    if (r_cnt == TRIG_LAST) begin
                        r_trigger <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (w_echo && !r_echo_prev) begin
                        r_med   <= MED_START;
                        r_cnt   <= CNT_START;
                        r_state <= S_MEAS;
                    end else if (r_cnt == TMO_LAST) begin
                        r_med        <= '0;
                        r_res_to     <= 1'b1;
                        r_res_dentro <= 1'b0;
                        r_valid      <= 1'b1;
                        r_state      <= S_RES;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_MEAS: begin
                    if (!w_echo) begin
                        r_res_to     <= 1'b0;
                        r_res_dentro <= w_hit;
                        r_valid      <= 1'b1;
                        r_state      <= S_RES;
                    end else if (r_cnt == UNIT_LAST) begin
                        r_cnt <= '0;
                        if (r_med == MED_PRE) begin
                            r_med        <= MED_MAX;
                            r_res_to     <= 1'b1;
                            r_res_dentro <= 1'b0;
                            r_valid      <= 1'b1;
                            r_state      <= S_RES;
                        end else begin
                            r_med <= r_med + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_RES: begin
                    if (i_res_ready) begin
                        r_dentro <= (r_dentro & ~w_oh_ch)
                                  | (r_res_dentro ? w_oh_ch : '0);
                        r_valid  <= 1'b0;
                        r_state  <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_ch < 3'(N_CH - 1)) begin
                        r_ch      <= r_ch + 3'd1;
                        r_cnt     <= '0;
                        r_trigger <= f_onehot(r_ch + 3'd1);
                        r_state   <= S_TRIG;
                    end else begin
                        r_acertou <= &r_dentro;
                        r_state   <= S_FIM;
                    end
                end
                S_FIM: begin
                    if (i_continuo) begin
                        r_state   <= S_TRIG;
                        r_ch      <= '0;
                        r_cnt     <= '0;
                        r_upper   <= i_upperL;
                        r_lower   <= i_lowerL;
                        r_trigger <= f_onehot(3'd0);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_trigger     = r_trigger;
    assign o_res_valid   = r_valid;
    assign o_res_canal   = r_ch;
    assign o_res_medida  = r_med;
    assign o_res_dentro  = r_res_dentro;
    assign o_res_timeout = r_res_to;
    assign o_dentro      = r_dentro;
    assign o_acertou     = r_acertou;
    assign o_db_estado   = r_state;

endmodule

// File: tb/tb_medidor_faixa_mc.sv
// Bench for medidor_faixa_mc: directed and random scans against
// an arithmetic model of pulse width, window and saturation.
module tb_medidor_faixa_mc;

    localparam int N_CH = 2;
    localparam int W    = 12;
    localparam int CPU  = 4;
    localparam int TRIG = 3;
    localparam int TMO  = 100;
    localparam int MAXV = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            medir = 1'b0;
    logic            continuo = 1'b0;
    logic            ready = 1'b0;
    logic [W-1:0]    upper = '0;
    logic [W-1:0]    lower = '0;
    logic [N_CH-1:0] echo = '0;

    logic [N_CH-1:0] o_trigger;
    logic            o_res_valid;
    logic [2:0]      o_res_canal;
    logic [W-1:0]    o_res_medida;
    logic            o_res_dentro;
    logic            o_res_timeout;
    logic [N_CH-1:0] o_dentro;
    logic            o_acertou;
    logic [3:0]      o_db_estado;

    int total = 0;
    int bad = 0;
    logic [N_CH-1:0] exp_dentro = '0;
    int plan_len[N_CH];
    int plan_dly[N_CH];
    int plan_bp[N_CH];

    medidor_faixa_mc #(
        .N_CH(N_CH),
        .W(W),
        .CLK_PER_UNIT(CPU),
        .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_medir(medir),
        .i_continuo(continuo),
        .i_upperL(upper),
        .i_lowerL(lower),
        .i_echo(echo),
        .o_trigger(o_trigger),
        .o_res_valid(o_res_valid),
        .i_res_ready(ready),
        .o_res_canal(o_res_canal),
        .o_res_medida(o_res_medida),
        .o_res_dentro(o_res_dentro),
        .o_res_timeout(o_res_timeout),
        .o_dentro(o_dentro),
        .o_acertou(o_acertou),
        .o_db_estado(o_db_estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Distance is whole units of echo-high time, clipped at full scale.
    function automatic int m_med(input int len);
        int m;
        m = len / CPU;
        if (m > MAXV) m = MAXV;
        return m;
    endfunction

    function automatic bit m_to(input int len);
        return (len == 0) || (len / CPU >= MAXV);
    endfunction

    function automatic bit m_in(input int len, input int lo, input int up);
        return !m_to(len) && lo <= m_med(len) && m_med(len) <= up;
    endfunction

    task automatic do_channel(input int c, input int dly, input int len,
                              input int bp, input int lo, input int up,
                              input bit poke);
        int n;
        int th;
        int em;
        bit et;
        bit ed;
        em = m_med(len);
        et = m_to(len);
        ed = m_in(len, lo, up);
        n = 0;
        while (o_trigger[c] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("trig_onehot", 32'(o_trigger), 32'(1 << c));
        th = 0;
        while (o_trigger[c] === 1'b1 && th < 50) begin
            @(negedge clk);
            th++;
        end
        chk("trig_len", 32'(th), 32'(TRIG));
        chk("wait_state", 32'(o_db_estado), 32'd2);
        repeat (dly) @(negedge clk);
        if (len > 0) begin
            echo[c] = 1'b1;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                if (poke && k == 20) begin
                    chk("meas_state", 32'(o_db_estado), 32'd3);
                    medir = 1'b1;
                    continuo = 1'b0;
                end
                if (poke && k == 21) medir = 1'b0;
            end
            echo[c] = 1'b0;
        end
        n = 0;
        while (o_res_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid", 32'(o_res_valid), 32'd1);
        chk("res_canal", 32'(o_res_canal), 32'(c));
        chk("res_medida", 32'(o_res_medida), 32'(em));
        chk("res_timeout", 32'(o_res_timeout), 32'(et));
        chk("res_dentro", 32'(o_res_dentro), 32'(ed));
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            chk("bp_valid", 32'(o_res_valid), 32'd1);
            chk("bp_medida", 32'(o_res_medida), 32'(em));
            chk("bp_flags", 32'({o_res_dentro, o_res_timeout}),
                32'({ed, et}));
            chk("bp_state", 32'(o_db_estado), 32'd4);
            chk("bp_trig", 32'(o_trigger), 32'd0);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        exp_dentro[c] = ed;
        chk("dentro", 32'(o_dentro), 32'(exp_dentro));
        chk("next_state", 32'(o_db_estado), 32'd5);
        chk("valid_drop", 32'(o_res_valid), 32'd0);
    endtask

    task automatic scan(input int lo, input int up, input bit start,
                        input bit poke, input int nlo, input int nup);
        bit all;
        if (start) begin
            lower = W'(lo);
            upper = W'(up);
            medir = 1'b1;
            @(negedge clk);
            medir = 1'b0;
        end
        lower = W'($urandom);
        upper = W'($urandom);
        for (int c = 0; c < N_CH; c++) begin
            do_channel(c, plan_dly[c], plan_len[c], plan_bp[c], lo, up,
                       poke && c == 0);
        end
        lower = W'(nlo);
        upper = W'(nup);
        all = &exp_dentro;
        @(negedge clk);
        chk("fim_state", 32'(o_db_estado), 32'd6);
        chk("acertou", 32'(o_acertou), 32'(all));
        @(negedge clk);
        chk("acertou_off", 32'(o_acertou), 32'd0);
        chk("after_fim", 32'(o_db_estado), continuo ? 32'd1 : 32'd0);
    endtask

    task automatic plan(input int l0, input int l1, input int b0,
                        input int b1);
        plan_len[0] = l0;
        plan_len[1] = l1;
        plan_bp[0] = b0;
        plan_bp[1] = b1;
        plan_dly[0] = int'($urandom_range(1, 20));
        plan_dly[1] = int'($urandom_range(1, 20));
    endtask

    initial begin
        int lo;
        int up;
        int n;
        @(negedge clk);
        chk("rst_state", 32'(o_db_estado), 32'd0);
        chk("rst_outs", 32'({o_trigger, o_res_valid, o_dentro, o_acertou}),
            32'd0);
        chk("rst_res", 32'({o_res_canal, o_res_medida, o_res_dentro,
                            o_res_timeout}), 32'd0);
        rst_n = 1'b1;

        plan(60, 100, 0, 0);
        scan(10, 20, 1'b1, 1'b0, 10, 20);
        plan(60, 60, 0, 0);
        scan(10, 20, 1'b1, 1'b0, 10, 20);
        plan(60, 0, 0, 0);
        scan(10, 20, 1'b1, 1'b0, 10, 20);
        plan(60, 60, 20, 0);
        scan(10, 20, 1'b1, 1'b0, 10, 20);
        plan(63, 67, 0, 2);
        scan(15, 16, 1'b1, 1'b0, 15, 16);
        plan(60, 60, 0, 0);
        scan(20, 10, 1'b1, 1'b0, 20, 10);
        plan(1, 7, 1, 0);
        scan(0, 1, 1'b1, 1'b0, 0, 1);
        plan(16400, 60, 0, 0);
        scan(0, MAXV, 1'b1, 1'b0, 0, MAXV);

        for (int i = 0; i < 6; i++) begin
            lo = int'($urandom_range(0, 60));
            up = int'($urandom_range(0, 60));
            plan(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300)),
                 int'($urandom_range(1, 300)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            scan(lo, up, 1'b1, 1'b0, lo, up);
        end

        continuo = 1'b1;
        plan(60, 60, 0, 0);
        scan(10, 20, 1'b1, 1'b0, 10, 20);
        plan(60, 80, 0, 1);
        scan(10, 20, 1'b0, 1'b1, 10, 20);
        repeat (5) @(negedge clk);
        chk("medir_not_queued", 32'(o_db_estado), 32'd0);

        lower = W'(10);
        upper = W'(20);
        medir = 1'b1;
        @(negedge clk);
        medir = 1'b0;
        n = 0;
        while (o_trigger[0] === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        echo[0] = 1'b1;
        repeat (30) @(negedge clk);
        chk("pre_rst_state", 32'(o_db_estado), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(o_db_estado), 32'd0);
        chk("arst_outs", 32'({o_trigger, o_res_valid, o_dentro, o_acertou}),
            32'd0);
        chk("arst_res", 32'({o_res_medida, o_res_dentro, o_res_timeout}),
            32'd0);
        echo[0] = 1'b0;
        exp_dentro = '0;
        @(negedge clk);
        rst_n = 1'b1;
        plan(60, 60, 0, 0);
        scan(10, 20, 1'b1, 1'b0, 10, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
